// File: rtl/sensor_frame_tx.sv
// ---------------------------------------------------------------------------
// sensor_frame_tx
//   Transmitter side of the sensor link. On an accepted start request it
//   snapshots four sensor readings and shifts them out on one wire, sensor1
//   first. Each sensor goes out as a framed word:
//     start(0) | index[1:0] LSB first | data LSB first | even parity | stop(1)
//   Every bit is held for CLKS_PER_BIT clocks and the line idles high.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (aborts a frame in flight)
//   start      : frame request, honoured only while idle
//   sensor1..4 : sensor readings, snapshotted when start is accepted
//   serial_out : serial line (registered, idles high)
//   busy       : high while a frame is in progress (registered)
//   done       : one-cycle pulse on the edge the frame completes (registered)
// ---------------------------------------------------------------------------
module sensor_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] sensor1,
  input  logic [DATA_WIDTH-1:0] sensor2,
  input  logic [DATA_WIDTH-1:0] sensor3,
  input  logic [DATA_WIDTH-1:0] sensor4,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  done
);

  localparam int              BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]      TIMER_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_INDEX  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  // Even parity over the index and data bits of one sensor word.
  function automatic logic f_even_parity(input logic [1:0]            idx,
                                         input logic [DATA_WIDTH-1:0] data);
    return ^{idx, data};
  endfunction

  state_t                r_state;
  state_t                w_state_n;
  logic [7:0]            r_timer;
  logic [7:0]            w_timer_n;
  logic [1:0]            r_sensor;
  logic [1:0]            w_sensor_n;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      w_bit_n;
  logic [DATA_WIDTH-1:0] r_data [4];
  logic                  w_latch;
  logic                  w_wrap;
  logic                  w_serial_n;
  logic                  w_busy_n;
  logic                  w_done_n;
  logic                  r_serial;
  logic                  r_busy;
  logic                  r_done;

  assign w_wrap     = (r_timer == TIMER_LAST);
  assign serial_out = r_serial;
  assign busy       = r_busy;
  assign done       = r_done;

  // Next-state logic: bit timer, field bit counter, sensor counter, FSM.
  always_comb begin
    w_state_n  = r_state;
    w_timer_n  = r_timer;
    w_sensor_n = r_sensor;
    w_bit_n    = r_bit;
    w_latch    = 1'b0;
    w_done_n   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n  = ST_START;
          w_timer_n  = 8'd0;
          w_sensor_n = 2'd0;
          w_bit_n    = '0;
          w_latch    = 1'b1;
        end else begin
          w_timer_n = 8'd0;
        end
      end
      ST_START: begin
        if (w_wrap) begin
          w_timer_n = 8'd0;
          w_bit_n   = '0;
          w_state_n = ST_INDEX;
        end else begin
          w_timer_n = r_timer + 8'd1;
        end
      end
      ST_INDEX: begin
        if (w_wrap) begin
          w_timer_n = 8'd0;
          if (r_bit == IDX_LAST) begin
            w_bit_n   = '0;
            w_state_n = ST_DATA;
          end else begin
            w_bit_n = r_bit + BIT_W'(1);
          end
        end else begin
          w_timer_n = r_timer + 8'd1;
        end
      end
      ST_DATA: begin
        if (w_wrap) begin
          w_timer_n = 8'd0;
          if (r_bit == DATA_LAST) begin
            w_bit_n   = '0;
            w_state_n = ST_PARITY;
          end else begin
            w_bit_n = r_bit + BIT_W'(1);
          end
        end else begin
          w_timer_n = r_timer + 8'd1;
        end
      end
      ST_PARITY: begin
        if (w_wrap) begin
          w_timer_n = 8'd0;
          w_state_n = ST_STOP;
        end else begin
          w_timer_n = r_timer + 8'd1;
        end
      end
      ST_STOP: begin
        if (w_wrap) begin
          w_timer_n = 8'd0;
          if (r_sensor == 2'd3) begin
            // Last stop bit: back to idle and flag completion on this edge.
            w_state_n = ST_IDLE;
            w_done_n  = 1'b1;
          end else begin
            // No idle gap between sensors inside a frame.
            w_sensor_n = r_sensor + 2'd1;
            w_state_n  = ST_START;
          end
        end else begin
          w_timer_n = r_timer + 8'd1;
        end
      end
      default: begin
        w_state_n  = ST_IDLE;
        w_timer_n  = 8'd0;
        w_sensor_n = 2'd0;
        w_bit_n    = '0;
      end
    endcase
  end

  // Line value for the state being entered, so the registered output changes
  // on the same edge as the FSM. Data/parity read the snapshot, which is
  // always loaded well before the first data bit.
  always_comb begin
    w_serial_n = 1'b1;
    w_busy_n   = (w_state_n != ST_IDLE);
    case (w_state_n)
      ST_IDLE:   w_serial_n = 1'b1;
      ST_START:  w_serial_n = 1'b0;
      ST_INDEX:  w_serial_n = w_sensor_n[w_bit_n[0]];
      ST_DATA:   w_serial_n = r_data[w_sensor_n][w_bit_n];
      ST_PARITY: w_serial_n = f_even_parity(w_sensor_n, r_data[w_sensor_n]);
      ST_STOP:   w_serial_n = 1'b1;
      default:   w_serial_n = 1'b1;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_timer  <= 8'd0;
      r_sensor <= 2'd0;
      r_bit    <= '0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_timer  <= w_timer_n;
      r_sensor <= w_sensor_n;
      r_bit    <= w_bit_n;
      r_serial <= w_serial_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
    end
  end

  // Sensor snapshot, loaded only when a frame request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= '0;
      end
    end else if (w_latch) begin
      r_data[0] <= sensor1;
      r_data[1] <= sensor2;
      r_data[2] <= sensor3;
      r_data[3] <= sensor4;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= r_data[i];
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_sensor_frame_tx
//   Directed bench for sensor_frame_tx with default parameters. A table of
//   sensor tuples with hand-computed parity nibbles (bit n = parity bit of
//   sensor n) drives full frames that are compared cycle by cycle; extra
//   sequences cover reset, ignored start / snapshot, back-to-back frames and
//   mid-frame reset.
// ---------------------------------------------------------------------------
module tb_sensor_frame_tx;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int BITS  = DW + 5;
  localparam int FRAME = 4 * BITS * CPB;  // 208

  typedef struct packed {
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [DW-1:0] s3;
    logic [DW-1:0] s4;
    logic [3:0]    par;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] sensor1, sensor2, sensor3, sensor4;
  logic          serial_out, busy, done;

  int checks   = 0;
  int failures = 0;

  sensor_frame_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
    .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected serial bit sequence; bit j is the j-th bit on the wire.
  function automatic logic [4*BITS-1:0] build(input vec_t v);
    logic [4*BITS-1:0] f;
    logic [DW-1:0]     d;
    logic [1:0]        ix;
    int                b;
    f = '0;
    for (int n = 0; n < 4; n++) begin
      d  = (n == 0) ? v.s1 : (n == 1) ? v.s2 : (n == 2) ? v.s3 : v.s4;
      ix = 2'(n);
      b  = n * BITS;
      f[b]     = 1'b0;
      f[b + 1] = ix[0];
      f[b + 2] = ix[1];
      for (int i = 0; i < DW; i++) f[b + 3 + i] = d[i];
      f[b + 3 + DW] = v.par[n];
      f[b + 4 + DW] = 1'b1;
    end
    return f;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle before frame", busy, 1'b0);
  endtask

  // Send one frame and check it; inject=1 pulses start and changes the
  // sensor inputs in mid-frame, which must have no effect.
  task automatic run_frame(input vec_t v, input bit inject, input string tag);
    logic [4*BITS-1:0] exp;
    int                dones;
    exp = build(v);
    wait_idle();
    sensor1 = v.s1; sensor2 = v.s2; sensor3 = v.s3; sensor4 = v.s4;
    start = 1'b1;
    @(negedge clk);            // accept edge k has just passed; t = 0
    start = 1'b0;
    dones = 0;
    for (int t = 0; t < FRAME; t++) begin
      chk($sformatf("%s serial t=%0d", tag, t), serial_out, exp[t / CPB]);
      chk($sformatf("%s busy t=%0d", tag, t), busy, 1'b1);
      if (done === 1'b1) dones++;
      if (inject && t == 49) begin
        start = 1'b1;
        sensor1 = 8'h3C; sensor2 = 8'h3C; sensor3 = 8'h3C; sensor4 = 8'h3C;
      end
      if (inject && t == 50) start = 1'b0;
      @(negedge clk);
    end
    chk_int({tag, " early done count"}, dones, 0);
    chk({tag, " done at 208"}, done, 1'b1);
    chk({tag, " busy low at 208"}, busy, 1'b0);
    chk({tag, " line high at 208"}, serial_out, 1'b1);
    @(negedge clk);
    chk({tag, " done single pulse"}, done, 1'b0);
    chk({tag, " stays idle"}, busy, 1'b0);
  endtask

  vec_t vecs [5];
  vec_t rv;
  logic [4*BITS-1:0] exp0;
  int d1, d2, dn, bad;

  initial begin
    // Hand-computed parity nibbles, bit n = parity of sensor n.
    vecs[0] = '{s1: 8'hA5, s2: 8'h01, s3: 8'hFF, s4: 8'h00, par: 4'b0100};
    vecs[1] = '{s1: 8'h00, s2: 8'h00, s3: 8'h00, s4: 8'h00, par: 4'b0110};
    vecs[2] = '{s1: 8'hFF, s2: 8'hFF, s3: 8'hFF, s4: 8'hFF, par: 4'b0110};
    vecs[3] = '{s1: 8'h80, s2: 8'h7F, s3: 8'h55, s4: 8'hC3, par: 4'b0101};
    vecs[4] = '{s1: 8'h12, s2: 8'h34, s3: 8'h56, s4: 8'h78, par: 4'b0100};

    // Reset held two cycles with start asserted: rst wins.
    rst = 1'b1; start = 1'b1;
    sensor1 = 8'h00; sensor2 = 8'h00; sensor3 = 8'h00; sensor4 = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("reset serial c%0d", i), serial_out, 1'b1);
      chk($sformatf("reset busy c%0d", i), busy, 1'b0);
      chk($sformatf("reset done c%0d", i), done, 1'b0);
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset serial c%0d", i), serial_out, 1'b1);
      chk($sformatf("post-reset busy c%0d", i), busy, 1'b0);
      chk($sformatf("post-reset done c%0d", i), done, 1'b0);
    end

    // Table of directed frames.
    for (int i = 0; i < 5; i++) run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Ignored start and snapshot while busy.
    run_frame(vecs[0], 1'b1, "inject");

    // Back-to-back: start held high through two full frames.
    exp0 = build(vecs[0]);
    sensor1 = vecs[0].s1; sensor2 = vecs[0].s2; sensor3 = vecs[0].s3; sensor4 = vecs[0].s4;
    start = 1'b1;
    @(negedge clk);
    d1 = -1; d2 = -1; bad = 0;
    for (int t = 0; t < 420; t++) begin
      if (done === 1'b1) begin
        if (d1 < 0) d1 = t;
        else if (d2 < 0) d2 = t;
      end
      if (t == 208) chk("b2b gap high", serial_out, 1'b1);
      if (t == 209) begin
        chk("b2b restart low", serial_out, 1'b0);
        chk("b2b restart busy", busy, 1'b1);
      end
      if (t >= 209 && t < 209 + FRAME && serial_out !== exp0[(t - 209) / CPB]) bad++;
      @(negedge clk);
    end
    start = 1'b0;
    chk_int("b2b first done", d1, 208);
    chk_int("b2b second done", d2, 417);
    chk_int("b2b second frame bit errors", bad, 0);
    wait_idle();

    // Mid-frame reset at cycle 100.
    sensor1 = vecs[3].s1; sensor2 = vecs[3].s2; sensor3 = vecs[3].s3; sensor4 = vecs[3].s4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 100; t++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort serial", serial_out, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    dn = 0; bad = 0;
    for (int t = 0; t < 250; t++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk_int("abort no done pulse", dn, 0);
    chk_int("abort line idle cycles bad", bad, 0);
    run_frame(vecs[3], 1'b0, "after-abort");

    // A few random tuples; parity computed from the link definition.
    for (int i = 0; i < 6; i++) begin
      rv.s1 = 8'($urandom_range(0, 255));
      rv.s2 = 8'($urandom_range(0, 255));
      rv.s3 = 8'($urandom_range(0, 255));
      rv.s4 = 8'($urandom_range(0, 255));
      rv.par = {^{2'd3, rv.s4}, ^{2'd2, rv.s3}, ^{2'd1, rv.s2}, ^{2'd0, rv.s1}};
      run_frame(rv, 1'b0, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
